uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 132 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO ahead of a one-byte-at-a-time transmitter; write-to-send latency is 2 edges into an idle, empty buffer.
// Writes while full are dropped and flagged (ovf); the next send waits for tx_done or the WAIT timeout (tmo_err).
module uart_tx_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int TO_CYC = 600000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  input  logic          tx_done,
  output logic [7:0]    tx_data,
  output logic          tx_send_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          ovf,
  output logic          tmo_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [19:0] TO_LAST  = 20'(TO_CYC - 1);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [19:0]   wait_cnt;
  logic          wr_acc;
  logic          pop;
  logic          tmo_hit;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign wr_acc  = wr_en & ~full;
  assign pop     = (state == IDLE) & ~empty;
  // A done pulse on the final WAIT cycle counts as success, not timeout.
  assign tmo_hit = (state == WAIT) & ~tx_done & (wait_cnt == TO_LAST);

  // Storage is deliberately left out of reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_send_en <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data    <= mem[rd_ptr];
            tx_send_en <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          tx_send_en <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          // A timed-out byte is simply abandoned; there is no retry.
          if (tx_done || tmo_hit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
          end
        end
        default: begin
          tx_send_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle as ovf_clr wins.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovf     <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      if (wr_en && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (tmo_hit) begin
        tmo_err <= 1'b1;
      end else if (ovf_clr) begin
        tmo_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a send-order scoreboard checked on every tx_send_en pulse.
module tb_uart_tx_buffer;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int TO_CYC = 100;

  logic          Clk     = 1'b0;
  logic          Rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          tx_done = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_send_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          busy;
  logic          ovf;
  logic          tmo_err;

  int            n_assert  = 0;
  int            n_fail    = 0;
  int            sends     = 0;
  logic          prev_send = 1'b0;
  logic [7:0]    exp_q[$];

  always #5 Clk = ~Clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .AW(AW), .TO_CYC(TO_CYC)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .ovf_clr    (ovf_clr),
    .tx_done    (tx_done),
    .tx_data    (tx_data),
    .tx_send_en (tx_send_en),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .busy       (busy),
    .ovf        (ovf),
    .tmo_err    (tmo_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: every send pulse must be single-cycle and carry the oldest accepted byte.
  always @(negedge Clk) begin
    if (Rst_n && tx_send_en) begin
      sends++;
      check("send_one_cycle", 32'(prev_send), 32'd0);
      check("send_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("send_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_send = tx_send_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int peak;
    int t;

    // Reset state
    Rst_n = 1'b0;
    repeat (2) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send_en", 32'(tx_send_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_tmo_err", 32'(tmo_err), 32'd0);
    Rst_n = 1'b1;
    tick();

    // Single byte: write edge, then pop edge raises tx_send_en
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("single_count_after_write", 32'(count), 32'd1);
    check("single_no_send_yet", 32'(tx_send_en), 32'd0);
    tick();
    check("single_send_en", 32'(tx_send_en), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_busy", 32'(busy), 32'd1);
    check("single_count_after_pop", 32'(count), 32'd0);
    tick();
    check("single_send_dropped", 32'(tx_send_en), 32'd0);
    check("single_busy_wait", 32'(busy), 32'd1);
    check("single_data_hold", 32'(tx_data), 32'hA5);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_empty", 32'(empty), 32'd1);
    check("single_send_count", 32'(sends), 32'd1);

    // Burst of five, tx_done 20 cycles after each send
    base = sends;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    check("burst_peak_count", 32'(peak), 32'd4);
    for (int k = 1; k <= 5; k++) begin
      t = 0;
      while (sends < base + k && t < 300) begin
        tick();
        t++;
      end
      check("burst_send_seen", 32'(sends >= base + k), 32'd1);
      repeat (20) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    repeat (5) tick();
    check("burst_total_sends", 32'(sends - base), 32'd5);
    check("burst_scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("burst_idle", 32'(busy), 32'd0);
    check("burst_empty", 32'(empty), 32'd1);

    // Overflow: 17 accepted (one popped), 18th dropped
    base = sends;
    for (int i = 1; i <= 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(16 + i); exp_q.push_back(8'(16 + i));
      tick();
    end
    check("ovf_count_full", 32'(count), 32'd16);
    check("ovf_full_flag", 32'(full), 32'd1);
    check("ovf_not_yet", 32'(ovf), 32'd0);
    wr_data = 8'hEE;
    tick();
    check("ovf_count_held", 32'(count), 32'd16);
    check("ovf_set", 32'(ovf), 32'd1);
    wr_data = 8'hEF; ovf_clr = 1'b1;
    tick();
    check("ovf_set_beats_clear", 32'(ovf), 32'd1);
    wr_en = 1'b0;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    check("ovf_one_send_only", 32'(sends - base), 32'd1);

    // Drain to DEPTH-1 in IDLE, then write and pop on the same edge
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("drain_idle_full", 32'(count), 32'd16);
    tick();
    check("drain_pop_count", 32'(count), 32'd15);
    check("drain_pop_send", 32'(tx_send_en), 32'd1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("simul_pre_count", 32'(count), 32'd15);
    check("simul_pre_idle", 32'(busy), 32'd0);
    wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    tick();
    wr_en = 1'b0;
    check("simul_count_same", 32'(count), 32'd15);
    check("simul_not_full", 32'(full), 32'd0);
    check("simul_send", 32'(tx_send_en), 32'd1);

    // Timeout: IDLE exactly TO_CYC cycles after WAIT entry, then next byte goes
    tick();
    repeat (TO_CYC - 1) tick();
    check("tmo_still_waiting", 32'(busy), 32'd1);
    check("tmo_not_yet", 32'(tmo_err), 32'd0);
    tick();
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_err_set", 32'(tmo_err), 32'd1);
    tick();
    check("tmo_next_send", 32'(tx_send_en), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("tmo_err_cleared", 32'(tmo_err), 32'd0);

    // Reset with a full backlog, then a clean 3-queued reset mid-WAIT
    Rst_n = 1'b0;
    #2;
    check("rst_backlog_count", 32'(count), 32'd0);
    exp_q.delete();
    tick();
    Rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC1 + i); exp_q.push_back(8'(8'hC1 + i));
      tick();
    end
    wr_en = 1'b0;
    check("midwait_queued", 32'(count), 32'd3);
    check("midwait_busy", 32'(busy), 32'd1);
    Rst_n = 1'b0;
    #2;
    check("midwait_rst_count", 32'(count), 32'd0);
    check("midwait_rst_busy", 32'(busy), 32'd0);
    check("midwait_rst_send_en", 32'(tx_send_en), 32'd0);
    check("midwait_rst_empty", 32'(empty), 32'd1);
    check("midwait_rst_tx_data", 32'(tx_data), 32'h00);
    exp_q.delete();
    base = sends;
    tick();
    Rst_n = 1'b1;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("post_rst_done_ignored", 32'(busy), 32'd0);
    repeat (30) tick();
    check("post_rst_no_sends", 32'(sends - base), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
